// File: rtl/host_mem_line_writer_pkg.sv
// Shared types and constants for the host_mem line-write path.
// Typedef widths match the default parameterisation of host_mem_line_writer.
package host_mem_line_writer_pkg;

    localparam int PKG_ADDR_WIDTH = 64;
    localparam int PKG_DATA_WIDTH = 512;
    localparam int PKG_ID_WIDTH   = 4;
    localparam int LINE_OFFSET    = 6;

    typedef logic [PKG_ADDR_WIDTH-1:0]             t_byte_addr;
    typedef logic [PKG_ADDR_WIDTH-LINE_OFFSET-1:0] t_line_addr;
    typedef logic [PKG_ID_WIDTH-1:0]               t_axi_id;
    typedef logic [PKG_DATA_WIDTH-1:0]             t_line_data;

    localparam logic [2:0] AXI_SIZE_64B    = 3'b110;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int ERR_WIDTH     = 4;
    localparam int ERR_RESP      = 0;
    localparam int ERR_UNDERFLOW = 1;
    localparam int ERR_ID_ORDER  = 2;
    localparam int ERR_RSVD      = 3;

    function automatic t_byte_addr line_to_byte(input t_line_addr line_addr);
        return {line_addr, {LINE_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/host_mem_wr_credit_ctr.sv
// Outstanding-write credit counter: +1 per AW, -1 per B, flags B with no credit in use.
module host_mem_wr_credit_ctr #(
    parameter  int MAX_OUTSTANDING = 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_count_next,
    output logic             o_full,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_count;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_count_next = r_count;
        o_underflow  = 1'b0;
        if (i_inc && !i_dec) begin
            o_count_next = r_count + CNT_W'(1);
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) begin
                o_underflow = 1'b1;
            end else begin
                o_count_next = r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= o_count_next;
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/host_mem_line_writer.sv
// One-line AXI-MM write stage: command register -> independent AW/W, B credit tracking, CSR status.
// Optional B-ID order checking is enabled by defining HOST_MEM_LINE_WRITER_ORDER_CHECK_EN.
module host_mem_line_writer
    import host_mem_line_writer_pkg::*;
#(
    parameter  int ADDR_WIDTH      = 64,
    parameter  int DATA_WIDTH      = 512,
    parameter  int ID_WIDTH        = 4,
    parameter  int MAX_OUTSTANDING = 8,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-7:0]   cmd_line_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ADDR_WIDTH-1:0]   aw_addr,
    output logic [ID_WIDTH-1:0]     aw_id,
    output logic [2:0]              aw_size,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    w_last,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [ID_WIDTH-1:0]     b_id,
    input  logic [1:0]              b_resp,
    input  logic                    err_clear,
    output logic [31:0]             done_count,
    output logic [CNT_W-1:0]        outstanding,
    output logic [3:0]              err_status,
    output logic                    idle
);

    logic                  r_aw_pend;
    logic                  r_w_pend;
    logic [ADDR_WIDTH-7:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_data;
    logic [ID_WIDTH-1:0]   r_aw_id;
    logic [31:0]           r_done_count;
    logic [ERR_WIDTH-1:0]  r_err;
    logic                  r_idle;

    logic                  w_cmd_hs;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_b_hs;
    logic                  w_b_ok;
    logic                  w_full;
    logic                  w_underflow;
    logic                  w_id_err;
    logic                  w_aw_pend_next;
    logic                  w_w_pend_next;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      w_count_next;
    logic [ERR_WIDTH-1:0]  w_err_next;

    assign cmd_ready = !r_aw_pend && !r_w_pend && !w_full;
    assign w_cmd_hs  = cmd_valid && cmd_ready;
    assign w_aw_hs   = r_aw_pend && awready;
    assign w_w_hs    = r_w_pend && wready;
    assign w_b_hs    = bvalid;
    assign w_b_ok    = w_b_hs && !w_underflow;

    host_mem_wr_credit_ctr #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_aw_hs),
        .i_dec       (w_b_hs),
        .o_count     (w_count),
        .o_count_next(w_count_next),
        .o_full      (w_full),
        .o_underflow (w_underflow)
    );

    // Accept only fires when both flags are already clear, so it never races a handshake.
    always_comb begin
        w_aw_pend_next = r_aw_pend && !w_aw_hs;
        w_w_pend_next  = r_w_pend && !w_w_hs;
        if (w_cmd_hs) begin
            w_aw_pend_next = 1'b1;
            w_w_pend_next  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aw_pend    <= 1'b0;
            r_w_pend     <= 1'b0;
            r_aw_id      <= '0;
            r_done_count <= '0;
            r_err        <= '0;
            r_idle       <= 1'b1;
        end else begin
            r_aw_pend <= w_aw_pend_next;
            r_w_pend  <= w_w_pend_next;
            r_err     <= w_err_next;
            r_idle    <= !w_aw_pend_next && !w_w_pend_next && (w_count_next == '0);
            if (w_aw_hs) begin
                r_aw_id <= r_aw_id + ID_WIDTH'(1);
            end
            if (w_b_ok) begin
                r_done_count <= r_done_count + 32'd1;
            end
        end
    end

    // NOTE: the payload register is plain datapath; pend flags qualify it, so it has no reset.
    always_ff @(posedge clk) begin
        if (w_cmd_hs) begin
            r_cmd_addr <= cmd_line_addr;
            r_cmd_data <= cmd_data;
        end
    end

`ifdef HOST_MEM_LINE_WRITER_ORDER_CHECK_EN
    logic [ID_WIDTH-1:0] r_exp_id;
    logic                w_unused;

    assign w_id_err = w_b_ok && (b_id != r_exp_id);
    assign w_unused = b_resp[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp_id <= '0;
        end else if (w_b_ok) begin
            r_exp_id <= b_id + ID_WIDTH'(1);
        end
    end
`else
    logic w_unused;

    assign w_id_err = 1'b0;
    assign w_unused = ^{b_resp[0], b_id};
`endif

    // A coincident new error survives err_clear.
    always_comb begin
        w_err_next = err_clear ? '0 : r_err;
        if (w_b_hs && b_resp[1]) begin
            w_err_next[ERR_RESP] = 1'b1;
        end
        if (w_underflow) begin
            w_err_next[ERR_UNDERFLOW] = 1'b1;
        end
        if (w_id_err) begin
            w_err_next[ERR_ID_ORDER] = 1'b1;
        end
        w_err_next[ERR_RSVD] = 1'b0;
    end

    assign awvalid     = r_aw_pend;
    assign aw_addr     = {r_cmd_addr, {LINE_OFFSET{1'b0}}};
    assign aw_id       = r_aw_id;
    assign aw_size     = AXI_SIZE_64B;
    assign wvalid      = r_w_pend;
    assign w_data      = r_cmd_data;
    assign w_strb      = '1;
    assign w_last      = 1'b1;
    assign bready      = 1'b1;
    assign done_count  = r_done_count;
    assign outstanding = w_count;
    assign err_status  = r_err;
    assign idle        = r_idle;

endmodule

// File: tb/tb_host_mem_line_writer.sv
// Scoreboard bench for host_mem_line_writer: AW/W expectations queued at accept, checked on handshake.
module tb_host_mem_line_writer;
    import host_mem_line_writer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    t_line_addr  cmd_line_addr = '0;
    t_line_data  cmd_data = '0;
    logic        awvalid;
    logic        awready = 1'b1;
    t_byte_addr  aw_addr;
    t_axi_id     aw_id;
    logic [2:0]  aw_size;
    logic        wvalid;
    logic        wready = 1'b1;
    t_line_data  w_data;
    logic [63:0] w_strb;
    logic        w_last;
    logic        bvalid = 1'b0;
    logic        bready;
    t_axi_id     b_id = '0;
    logic [1:0]  b_resp = '0;
    logic        err_clear = 1'b0;
    logic [31:0] done_count;
    logic [3:0]  outstanding;
    logic [3:0]  err_status;
    logic        idle;

    int checks = 0;
    int errors = 0;

    t_byte_addr exp_aw_addr_q[$];
    t_axi_id    exp_aw_id_q[$];
    t_line_data exp_w_q[$];
    t_axi_id    tb_next_id = '0;

    localparam logic [3:0] EXP_ORDER_ERR =
`ifdef HOST_MEM_LINE_WRITER_ORDER_CHECK_EN
        4'b0100;
`else
        4'b0000;
`endif

    host_mem_line_writer dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_line_addr(cmd_line_addr),
        .cmd_data     (cmd_data),
        .awvalid      (awvalid),
        .awready      (awready),
        .aw_addr      (aw_addr),
        .aw_id        (aw_id),
        .aw_size      (aw_size),
        .wvalid       (wvalid),
        .wready       (wready),
        .w_data       (w_data),
        .w_strb       (w_strb),
        .w_last       (w_last),
        .bvalid       (bvalid),
        .bready       (bready),
        .b_id         (b_id),
        .b_resp       (b_resp),
        .err_clear    (err_clear),
        .done_count   (done_count),
        .outstanding  (outstanding),
        .err_status   (err_status),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic t_line_data rand_line();
        t_line_data d;
        for (int i = 0; i < 16; i++) begin
            d[i*32 +: 32] = $urandom;
        end
        return d;
    endfunction

    task automatic push_exp(input t_line_addr a, input t_line_data d);
        exp_aw_addr_q.push_back(line_to_byte(a));
        exp_aw_id_q.push_back(tb_next_id);
        exp_w_q.push_back(d);
        tb_next_id = tb_next_id + 4'd1;
    endtask

    // Returns one cycle after the accepting edge.
    task automatic send_cmd(input t_line_addr a, input t_line_data d);
        bit got = 1'b0;
        cmd_valid     = 1'b1;
        cmd_line_addr = a;
        cmd_data      = d;
        for (int i = 0; i < 50 && !got; i++) begin
            if (cmd_ready) begin
                push_exp(a, d);
                got = 1'b1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!got) check("cmd_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_b(input t_axi_id id, input logic [1:0] resp);
        bvalid = 1'b1;
        b_id   = id;
        b_resp = resp;
        tick();
        bvalid = 1'b0;
    endtask

    task automatic write_full(input t_line_addr a, input t_line_data d, input t_axi_id id);
        send_cmd(a, d);
        tick();
        send_b(id, AXI_RESP_OKAY);
    endtask

    // Handshake monitor: pops the scoreboard and checks AW hold-stability.
    initial begin
        bit         aw_stall = 1'b0;
        t_byte_addr stall_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                aw_stall = 1'b0;
            end else begin
                if (aw_stall) begin
                    check("aw_hold_valid", awvalid, 1'b1);
                    check("aw_hold_addr", aw_addr, stall_addr);
                end
                if (awvalid && awready) begin
                    if (exp_aw_addr_q.size() == 0) begin
                        check("aw_unexpected", 1'b1, 1'b0);
                    end else begin
                        check("aw_addr", aw_addr, exp_aw_addr_q.pop_front());
                        check("aw_id", aw_id, exp_aw_id_q.pop_front());
                        check("aw_size", aw_size, AXI_SIZE_64B);
                    end
                end
                if (wvalid && wready) begin
                    if (exp_w_q.size() == 0) begin
                        check("w_unexpected", 1'b1, 1'b0);
                    end else begin
                        check("w_data", w_data, exp_w_q.pop_front());
                        check("w_strb", w_strb, {64{1'b1}});
                        check("w_last", w_last, 1'b1);
                    end
                end
                aw_stall   = awvalid && !awready;
                stall_addr = aw_addr;
            end
        end
    end

    initial begin
        t_line_data d;
        t_line_addr a9;

        tick();
        tick();
        check("rst_idle", idle, 1'b1);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_outstanding", outstanding, 4'd0);
        check("rst_done", done_count, 32'd0);
        check("rst_err", err_status, 4'd0);
        check("rst_aw_id", aw_id, 4'd0);
        reset = 1'b0;
        tick();
        check("cmd_ready_idle", cmd_ready, 1'b1);
        check("bready", bready, 1'b1);

        // Single write, both channels ready.
        d = rand_line();
        send_cmd(58'h1000, d);
        check("t1_awvalid", awvalid, 1'b1);
        check("t1_wvalid", wvalid, 1'b1);
        check("t1_aw_addr", aw_addr, 64'h40000);
        check("t1_not_idle", idle, 1'b0);
        tick();
        check("t1_outstanding", outstanding, 4'd1);
        check("t1_aw_done", awvalid, 1'b0);
        send_b(4'd0, AXI_RESP_OKAY);
        check("t1_done", done_count, 32'd1);
        check("t1_out0", outstanding, 4'd0);
        check("t1_idle", idle, 1'b1);

        // AW back-pressured: W finishes first, AW held.
        awready = 1'b0;
        send_cmd(58'h2345, rand_line());
        tick();
        check("t2_w_first", wvalid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t2_aw_held", awvalid, 1'b1);
            check("t2_cmd_blocked", cmd_ready, 1'b0);
            tick();
        end
        awready = 1'b1;
        tick();
        check("t2_aw_done", awvalid, 1'b0);
        check("t2_outstanding", outstanding, 4'd1);
        check("t2_cmd_ready", cmd_ready, 1'b1);
        send_b(4'd1, AXI_RESP_OKAY);
        check("t2_done", done_count, 32'd2);

        // Credit limit: 8 in flight, 9th waits for a B.
        for (int k = 0; k < 8; k++) begin
            send_cmd(t_line_addr'(58'h100 + k), rand_line());
        end
        tick();
        check("t3_out_full", outstanding, 4'd8);
        check("t3_ready_full", cmd_ready, 1'b0);
        a9 = 58'h3_0000;
        d  = rand_line();
        cmd_valid     = 1'b1;
        cmd_line_addr = a9;
        cmd_data      = d;
        tick();
        tick();
        check("t3_9th_blocked", awvalid, 1'b0);
        send_b(4'd2, AXI_RESP_OKAY);
        check("t3_out_after_b", outstanding, 4'd7);
        check("t3_ready_after_b", cmd_ready, 1'b1);
        push_exp(a9, d);
        tick();
        cmd_valid = 1'b0;
        check("t3_9th_awvalid", awvalid, 1'b1);
        tick();
        check("t3_out_refull", outstanding, 4'd8);
        for (int k = 3; k <= 10; k++) begin
            send_b(t_axi_id'(k), AXI_RESP_OKAY);
        end
        check("t3_drained", outstanding, 4'd0);
        check("t3_done", done_count, 32'd11);
        check("t3_idle", idle, 1'b1);

        // Error status: response error, clear, underflow, clear racing a new error.
        send_cmd(58'h44, rand_line());
        tick();
        send_b(4'd11, AXI_RESP_SLVERR);
        check("t4_slverr", err_status, 4'b0001);
        check("t4_done", done_count, 32'd12);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t4_cleared", err_status, 4'b0000);
        send_b(4'd0, AXI_RESP_OKAY);
        check("t4_underflow", err_status, 4'b0010);
        check("t4_uf_out", outstanding, 4'd0);
        check("t4_uf_done", done_count, 32'd12);
        send_cmd(58'h45, rand_line());
        tick();
        err_clear = 1'b1;
        bvalid    = 1'b1;
        b_id      = 4'd12;
        b_resp    = AXI_RESP_DECERR;
        tick();
        err_clear = 1'b0;
        bvalid    = 1'b0;
        check("t4_clear_vs_new", err_status, 4'b0001);
        check("t4_done2", done_count, 32'd13);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // ID wrap over 16 writes, then an out-of-order B id.
        for (int k = 0; k < 16; k++) begin
            write_full(t_line_addr'(58'h500 + k), rand_line(), t_axi_id'(13 + k));
        end
        check("t5_done", done_count, 32'd29);
        check("t5_aw_id_wrapped", aw_id, 4'd13);
        check("t5_no_err", err_status, 4'b0000);
        write_full(58'h600, rand_line(), 4'd13);
        write_full(58'h601, rand_line(), 4'd15);
        check("t5_order_err", err_status, EXP_ORDER_ERR);
        check("t5_done2", done_count, 32'd31);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Reset mid-operation.
        for (int k = 0; k < 3; k++) begin
            send_cmd(t_line_addr'(58'h700 + k), rand_line());
        end
        tick();
        check("t6_out3", outstanding, 4'd3);
        awready = 1'b0;
        send_cmd(58'h800, rand_line());
        tick();
        check("t6_aw_stalled", awvalid, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_rst_awvalid", awvalid, 1'b0);
        check("t6_rst_wvalid", wvalid, 1'b0);
        check("t6_rst_out", outstanding, 4'd0);
        check("t6_rst_done", done_count, 32'd0);
        check("t6_rst_idle", idle, 1'b1);
        exp_aw_addr_q.delete();
        exp_aw_id_q.delete();
        exp_w_q.delete();
        tb_next_id = '0;
        tick();
        reset   = 1'b0;
        awready = 1'b1;
        tick();
        write_full(58'h9ABC, rand_line(), 4'd0);
        check("t6_post_done", done_count, 32'd1);
        check("t6_post_idle", idle, 1'b1);
        check("t6_post_err", err_status, 4'b0000);

        tick();
        check("end_aw_q_empty", exp_aw_addr_q.size(), 0);
        check("end_w_q_empty", exp_w_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/host_mem_line_writer.md
Name: host_mem_line_writer

Overview:
- Downstream write stage between an AFU command source and the host_mem AXI-MM write channels (AW/W/B).
- Accepts one-line write commands (line address + 512-bit payload) on a valid/ready port.
- Issues AW and W independently, converting line address to byte address, and tracks outstanding B responses against a credit limit.
- Reports completion count and sticky error status for CSR readback.

Parameters:
ADDR_WIDTH, 64, host_mem byte-address width
DATA_WIDTH, 512, line width in bits (64-byte line)
ID_WIDTH, 4, AXI ID width
MAX_OUTSTANDING, 8, max AW-issued-but-B-pending writes (1..2^ID_WIDTH)

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active high
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_line_addr  in  ADDR_WIDTH-6  line address
cmd_data  in  DATA_WIDTH  line payload
awvalid  out  1  AW valid
awready  in  1  AW ready
aw_addr  out  ADDR_WIDTH  byte address = {cmd_line_addr, 6'b0}
aw_id  out  ID_WIDTH  rolling transaction ID
aw_size  out  3  constant 3'b110
wvalid  out  1  W valid
wready  in  1  W ready
w_data  out  DATA_WIDTH  payload
w_strb  out  DATA_WIDTH/8  all ones
w_last  out  1  constant 1
bvalid  in  1  B valid
bready  out  1  constant 1
b_id  in  ID_WIDTH  response ID
b_resp  in  2  response code
err_clear  in  1  clears err_status
done_count  out  32  completed B responses, wraps
outstanding  out  $clog2(MAX_OUTSTANDING+1)  current credit use
err_status  out  4  sticky: [0] SLVERR/DECERR, [1] B underflow, [2] ID order, [3] reserved 0
idle  out  1  command register empty && outstanding==0

Behaviour:
- Reset (async, active high): cmd register empty, awvalid=0, wvalid=0, aw_id=0, outstanding=0, done_count=0, err_status=0, idle=1. Reset mid-operation drops in-flight command and forgets outstanding.
- cmd_ready = command register empty && outstanding < MAX_OUTSTANDING. The register holds one command with two pending flags (aw_pend, w_pend), both set on accept.
- No combinational path from cmd_valid to awvalid/wvalid. AW/W earliest valid is the cycle after accept.
- awvalid = aw_pend; wvalid = w_pend. Each flag clears on its own handshake; either order or the same cycle. Register empties when both are clear. A new command is accepted no earlier than the following cycle (no same-cycle refill).
- awvalid/wvalid and payload are held stable until their handshake. awvalid never deasserts without awready.
- aw_id increments mod 2^ID_WIDTH on each AW handshake.
- outstanding: +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle. It never exceeds MAX_OUTSTANDING.
- A B handshake with outstanding==0 (including same cycle with no AW): set err_status[1], counter held at 0, done_count unchanged.
- Each valid B handshake increments done_count (wraps 2^32-1 -> 0).
- b_resp[1]==1 sets err_status[0].
- err_clear clears err_status the next cycle. If err_clear coincides with a new error, the error wins (bit set).
- idle is registered from next-state values.

Optional Feature:
- Macro HOST_MEM_LINE_WRITER_ORDER_CHECK_EN.
- Defined: a FIFO-free expected-ID counter increments per valid B. A B whose b_id differs from expected sets err_status[2], and the expected counter resyncs to b_id+1.
- Undefined: b_id is ignored and err_status[2] is constant 0.

Decomposition:
- Package host_mem_line_writer_pkg holds:
  - t_line_addr, t_byte_addr, t_axi_id, t_line_data typedefs
  - AXI_SIZE_64B=3'b110 and AXI_RESP_* constants
  - ERR_* bit index constants
- One sub-module, host_mem_wr_credit_ctr: outstanding counter with inc/dec/underflow flag, parameterized on MAX_OUTSTANDING.

Test Plan:
- Single command, line_addr=0x1000, awready=wready=1 -> AW one cycle after accept with aw_addr=0x40000, aw_id=0. W in the same cycle. B (resp=0) -> done_count=1, idle=1.
- wready=1, awready held 0 for 5 cycles -> W completes first, awvalid held steady with constant aw_addr. cmd_ready stays 0 until AW completes.
- MAX_OUTSTANDING=8, 9 back-to-back commands, no B -> outstanding reaches 8, cmd_ready=0. One B -> outstanding 7, 9th command accepted.
- B with resp=2'b10 -> err_status[0]=1. err_clear pulse -> 0. Unsolicited B at idle -> err_status[1]=1, outstanding stays 0.
- 16 writes -> aw_id wraps 15->0. With the macro, B ids 0,2 -> err_status[2]=1. Without the macro -> err_status[2]=0.
- Assert reset while awvalid=1 and outstanding=3 -> awvalid=0, wvalid=0, outstanding=0, done_count=0 immediately. Normal write after deassert.
